// File: rtl/dma_axi_arb.sv
// dma_axi_arb: shares one DMA AXI native port among N_REQ requesters, one burst per grant, round-robin.
// Define DMA_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module dma_axi_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = `AXI_ADDR_W,
  parameter int DATA_W = 32,
  parameter int LEN_W  = `AXI_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_address,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb,
  input  logic [N_REQ*LEN_W-1:0]    req_dma_len,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      m_valid,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_ready,
  output logic [LEN_W-1:0]          m_dma_len,
  input  logic                      m_dma_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W:0]   cand;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             in_grant;
  logic             beat_done;

  // Search starts at the pointer and wraps; cand is one bit wider so ptr+k never overflows.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ))
        cand = cand - (IDX_W+1)'(N_REQ);
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign in_grant  = (state == ST_GRANT);
  assign m_valid   = in_grant & req_valid[g_idx];
  assign beat_done = m_valid & m_ready;
  assign m_address = req_address[g_idx*ADDR_W +: ADDR_W];
  assign m_wdata   = req_wdata[g_idx*DATA_W +: DATA_W];
  assign m_wstrb   = in_grant ? req_wstrb[g_idx*STRB_W +: STRB_W] : '0;
  assign m_dma_len = len_q;
  assign req_ready = in_grant ? (grant & {N_REQ{m_ready}}) : '0;
  assign req_rdata = m_rdata;
  assign busy      = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      g_idx    <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_dma_ready && win_found) begin
            grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            g_idx    <= win_idx;
            len_q    <= req_dma_len[win_idx*LEN_W +: LEN_W];
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Compare before incrementing so a max-length burst never wraps the counter.
          if (beat_done) begin
            if (beat_cnt == len_q)
              state <= ST_DRAIN;
            else
              beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (m_dma_ready) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_next;

  assign ptr_next = (g_idx == IDX_W'(N_REQ-1)) ? '0 : g_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (state == ST_DRAIN && m_dma_ready)
      ptr <= ptr_next;
  end
`endif

endmodule

// File: tb/tb_dma_axi_arb.sv
// Scoreboard bench for dma_axi_arb: directed bursts push expected grants/beats, monitors pop and compare.
`timescale 1ns/1ps

module tb_dma_axi_arb;

  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_address;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_wstrb;
  logic [N*LW-1:0]   req_dma_len;
  logic [DW-1:0]     req_rdata;
  logic [N-1:0]      req_ready;
  logic              m_valid;
  logic [AW-1:0]     m_address;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic [DW-1:0]     m_rdata;
  logic              m_ready;
  logic [LW-1:0]     m_dma_len;
  logic              m_dma_ready;
  logic [N-1:0]      grant;
  logic              busy;

  dma_axi_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_address(req_address), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_dma_len(req_dma_len),
    .req_rdata(req_rdata), .req_ready(req_ready),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_dma_len(m_dma_len), .m_dma_ready(m_dma_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  len;
    logic        is_read;
    logic [31:0] rdata;
    logic [1:0]  ready;
  } beat_t;

  beat_t      beat_q[$];
  logic [1:0] grant_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic [1:0] prev_grant = '0;
  logic [1:0] t2_seq [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [7:0] l);
    req_valid[i]             = v;
    req_address[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW]    = d;
    req_wstrb[i*4 +: 4]      = s;
    req_dma_len[i*LW +: LW]  = l;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [7:0] l, input logic rd, input logic [31:0] r,
                           input logic [1:0] rdy);
    beat_t b;
    b = '{a, d, s, l, rd, r, rdy};
    beat_q.push_back(b);
  endtask

  // Beat monitor: every forwarded handshake must match the next expected beat.
  always @(negedge clk) begin : beat_mon
    beat_t b;
    if (!rst && m_valid && m_ready) begin
      if (beat_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL beat_extra: got addr 0x%0h, expected no beat at %0t", m_address, $time);
      end else begin
        b = beat_q.pop_front();
        check("beat_addr", m_address, b.addr);
        check("beat_wstrb", m_wstrb, b.wstrb);
        check("beat_len", m_dma_len, b.len);
        check("beat_ready", req_ready, b.ready);
        if (b.is_read) check("beat_rdata", req_rdata, b.rdata);
        else           check("beat_wdata", m_wdata, b.wdata);
      end
    end
  end

  // Grant monitor: every new nonzero grant must match the next expected owner.
  always @(negedge clk) begin
    if (grant !== prev_grant && grant != '0) begin
      if (grant_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL grant_extra: got %b, expected no grant at %0t", grant, $time);
      end else begin
        check("grant_order", grant, grant_q.pop_front());
      end
    end
    prev_grant <= grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    logic [4:0] rdy_seq;
`ifdef DMA_ARB_FIXED_PRIO_EN
    t2_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    t2_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    rst = 1'b1;
    req_valid = '0; req_address = '0; req_wdata = '0; req_wstrb = '0; req_dma_len = '0;
    m_rdata = '0; m_ready = 1'b1; m_dma_ready = 1'b1;
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_wstrb", m_wstrb, 4'h0);
    check("rst_len", m_dma_len, 8'd0);
    check("rst_ready", req_ready, 2'b00);
    tick();
    rst = 1'b0;
    tick();

    // Single requester 0, len 3 write burst.
    set_req(0, 1'b1, 32'h1000, 32'hA0, 4'hF, 8'd3);
    grant_q.push_back(2'b01);
    tick();
    check("t1_grant", grant, 2'b01);
    m_dma_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 32'h1000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 8'd3);
      push_beat(32'h1000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 8'd3, 1'b0, 32'h0, 2'b01);
      tick();
    end
    req_valid[0] = 1'b0;
    check("t1_drain_mvalid", m_valid, 1'b0);
    check("t1_drain_busy", busy, 1'b1);
    check("t1_drain_ready", req_ready, 2'b00);
    tick();
    check("t1_drain_hold", grant, 2'b01);
    m_dma_ready = 1'b1;
    tick();
    check("t1_release_grant", grant, 2'b00);
    check("t1_release_busy", busy, 1'b0);

    // Two requesters, len 0 each, continuously valid.
    set_req(0, 1'b1, 32'h2000, 32'hB0, 4'h3, 8'd0);
    set_req(1, 1'b1, 32'h3000, 32'hC0, 4'hC, 8'd0);
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(t2_seq[k]);
      if (t2_seq[k] == 2'b01) push_beat(32'h2000, 32'hB0, 4'h3, 8'd0, 1'b0, 32'h0, 2'b01);
      else                    push_beat(32'h3000, 32'hC0, 4'hC, 8'd0, 1'b0, 32'h0, 2'b10);
    end
    repeat (11) tick();
    req_valid = '0;
    repeat (2) tick();
    check("t2_idle_busy", busy, 1'b0);

    // Requester 1, len 2, m_ready toggling, len input changed mid-burst.
    set_req(1, 1'b1, 32'h4000, 32'hD0, 4'hF, 8'd2);
    grant_q.push_back(2'b10);
    tick();
    check("t3_grant", grant, 2'b10);
    set_req(0, 1'b1, 32'h5000, 32'h55, 4'hF, 8'd1);
    rdy_seq = 5'b10101;
    b = 0;
    for (int c = 0; c < 5; c++) begin
      m_ready = rdy_seq[c];
      if (c == 1) req_dma_len[LW +: LW] = 8'd7;
      set_req(1, 1'b1, 32'h4000 + 32'(4*b), 32'hD0 + 32'(b), 4'hF, req_dma_len[LW +: LW]);
      if (rdy_seq[c]) push_beat(32'h4000 + 32'(4*b), 32'hD0 + 32'(b), 4'hF, 8'd2, 1'b0, 32'h0, 2'b10);
      #1;
      check("t3_len_held", m_dma_len, 8'd2);
      check("t3_ready0_low", req_ready[0], 1'b0);
      tick();
      if (rdy_seq[c]) b++;
    end
    check("t3_drain_busy", busy, 1'b1);
    check("t3_drain_mvalid", m_valid, 1'b0);
    check("t3_drain_len", m_dma_len, 8'd2);
    req_valid = '0;
    m_ready = 1'b1;
    tick();
    check("t3_idle_grant", grant, 2'b00);

    // Read burst, len 1, from requester 0.
    set_req(0, 1'b1, 32'h6000, 32'h0, 4'h0, 8'd1);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 8'd0);
    grant_q.push_back(2'b01);
    tick();
    check("t4_grant", grant, 2'b01);
    for (int i = 0; i < 2; i++) begin
      m_rdata = 32'hE000 + 32'(i);
      set_req(0, 1'b1, 32'h6000 + 32'(4*i), 32'h0, 4'h0, 8'd1);
      push_beat(32'h6000 + 32'(4*i), 32'h0, 4'h0, 8'd1, 1'b1, 32'hE000 + 32'(i), 2'b01);
      tick();
    end
    req_valid = '0;
    tick();
    check("t4_idle_busy", busy, 1'b0);

    // m_dma_ready low blocks the grant; then reset mid-burst.
    m_dma_ready = 1'b0;
    set_req(0, 1'b1, 32'h7000, 32'hF0, 4'hF, 8'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_grant", grant, 2'b00);
    end
    m_dma_ready = 1'b1;
    grant_q.push_back(2'b01);
    tick();
    check("t5_grant", grant, 2'b01);
    for (int i = 0; i < 2; i++) begin
      set_req(0, 1'b1, 32'h7000 + 32'(4*i), 32'hF0 + 32'(i), 4'hF, 8'd3);
      push_beat(32'h7000 + 32'(4*i), 32'hF0 + 32'(i), 4'hF, 8'd3, 1'b0, 32'h0, 2'b01);
      tick();
    end
    rst = 1'b1;
    #1;
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_mvalid", m_valid, 1'b0);
    check("t6_rst_ready", req_ready, 2'b00);
    set_req(0, 1'b1, 32'h8000, 32'h11, 4'hF, 8'd0);
    set_req(1, 1'b1, 32'h9000, 32'h22, 4'hF, 8'd0);
    tick();
    rst = 1'b0;
    grant_q.push_back(2'b01);
    push_beat(32'h8000, 32'h11, 4'hF, 8'd0, 1'b0, 32'h0, 2'b01);
    tick();
    check("t6_first_grant", grant, 2'b01);
    tick();
    req_valid = '0;
    repeat (2) tick();

    check("beat_q_empty", 64'(beat_q.size()), 64'd0);
    check("grant_q_empty", 64'(grant_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
